// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory controller: access sizes, FSM states,
// per-entry control bits and the size-to-byte-count mapping.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_RDLAST,
    S_DONE
  } state_e;

  // Parameter-independent part of a queue entry; the top wraps it with
  // chan/addr/wdata whose widths depend on the instance parameters.
  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       kill;
  } ent_ctl_t;

  // Encoding 3 is treated as a word access.
  function automatic logic [2:0] size_bytes(logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// NCH-way request arbiter: round-robin starting at the pointer, or fixed
// priority (lowest index wins). Grants only while the queue has room.
module mem_ctrl_arb #(
  parameter int NCH     = 2,
  parameter int RR_MODE = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] valid_i,
  input  logic           not_full_i,
  output logic [NCH-1:0] grant_o
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] gidx;
  logic [PW-1:0] idx;
  logic [PW:0]   sum;
  logic          found;

  always_comb begin
    grant_o = '0;
    gidx    = '0;
    idx     = '0;
    sum     = '0;
    found   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (RR_MODE != 0) begin
        sum = {1'b0, ptr_q} + (PW+1)'(i);
        if (sum >= (PW+1)'(NCH)) sum = sum - (PW+1)'(NCH);
        idx = sum[PW-1:0];
      end else begin
        idx = PW'(i);
      end
      if (!found && not_full_i && valid_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        gidx         = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      ptr_q <= '0;
    else if (found && RR_MODE != 0) ptr_q <= (gidx == PW'(NCH-1)) ? '0 : gidx + PW'(1);
  end

endmodule

// File: rtl/mem_ctrl.sv
// Multi-client memory controller: arbitrates NCH channels into an in-order
// queue and serialises each access onto a byte-wide RAM port.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int             NCH        = 2,
  parameter int             DEPTH      = 8,
  parameter int             ADDR_W     = 32,
  parameter int             DATA_W     = 32,
  parameter int             RR_MODE    = 1,
  parameter logic [NCH-1:0] FLUSH_MASK = NCH'(1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        req_valid,
  output logic [NCH-1:0]        req_ready,
  input  logic [NCH-1:0]        req_we,
  input  logic [2*NCH-1:0]      req_size,
  input  logic [ADDR_W*NCH-1:0] req_addr,
  input  logic [DATA_W*NCH-1:0] req_wdata,
  output logic [NCH-1:0]        rsp_valid,
  output logic [DATA_W-1:0]     rsp_data,
  input  logic                  flush,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [7:0]            ram_wdata,
  output logic                  ram_we,
  input  logic [7:0]            ram_rdata
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int QW = $clog2(DEPTH);

  typedef struct packed {
    logic [CW-1:0]     chan;
    ent_ctl_t          ctl;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } ent_t;

  ent_t              q_mem [DEPTH];
  logic [DEPTH-1:0]  kill_q;
  logic [QW-1:0]     wr_q, rd_q;
  logic [QW:0]       cnt_q;
  logic [NCH-1:0]    grant;
  logic              push, pop, not_full, empty;
  ent_t              new_ent, head, cur_q, cur_d;
  state_e            state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [2:0]        nb;
  logic [DATA_W-1:0] rbuf_q, rbuf_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_wdata_q, ram_wdata_d;
  logic              ram_we_q, ram_we_d;

  function automatic logic killable(ent_t e);
    return !e.ctl.we && FLUSH_MASK[e.chan];
  endfunction

  assign not_full = rst && (cnt_q != (QW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign push     = |grant;
  assign req_ready = grant;

  mem_ctrl_arb #(.NCH(NCH), .RR_MODE(RR_MODE)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (req_valid),
    .not_full_i (not_full),
    .grant_o    (grant)
  );

  always_comb begin
    new_ent = '0;
    for (int c = 0; c < NCH; c++) begin
      if (grant[c]) begin
        new_ent.chan     = CW'(c);
        new_ent.ctl.we   = req_we[c];
        new_ent.ctl.size = req_size[2*c +: 2];
        new_ent.addr     = req_addr[c*ADDR_W +: ADDR_W];
        new_ent.wdata    = req_wdata[c*DATA_W +: DATA_W];
      end
    end
  end

  // Kill bits live beside the storage so a flush can mark every slot at once.
  always_comb begin
    head          = q_mem[rd_q];
    head.ctl.kill = kill_q[rd_q];
  end

  always_ff @(posedge clk) begin
    if (push) q_mem[wr_q] <= new_ent;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kill_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (flush && killable(q_mem[i])) kill_q[i] <= 1'b1;
      if (push) kill_q[wr_q] <= 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    cur_d       = cur_q;
    rbuf_d      = rbuf_q;
    pop         = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = 8'h00;
    ram_we_d    = 1'b0;
    nb          = size_bytes(cur_q.ctl.size);
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (!head.ctl.kill) begin
            state_d           = S_XFER;
            k_d               = '0;
            cur_d             = head;
            cur_d.ctl.kill    = flush && killable(head);
            rbuf_d            = '0;
            ram_addr_d        = head.addr;
            ram_we_d          = head.ctl.we;
            ram_wdata_d       = head.ctl.we ? head.wdata[7:0] : 8'h00;
          end
        end
      end
      S_XFER: begin
        // RAM data lags the address by one cycle, so byte k-1 arrives now.
        if (!cur_q.ctl.we && k_q != 2'd0) rbuf_d[{k_q - 2'd1, 3'b000} +: 8] = ram_rdata;
        if ({1'b0, k_q} == nb - 3'd1) begin
          state_d = cur_q.ctl.we ? S_DONE : S_RDLAST;
        end else begin
          k_d         = k_q + 2'd1;
          ram_addr_d  = cur_q.addr + ADDR_W'(k_d);
          ram_we_d    = cur_q.ctl.we;
          ram_wdata_d = cur_q.ctl.we ? cur_q.wdata[{k_d, 3'b000} +: 8] : 8'h00;
        end
      end
      S_RDLAST: begin
        rbuf_d[{nb[1:0] - 2'd1, 3'b000} +: 8] = ram_rdata;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush && state_q != S_IDLE && killable(cur_q)) cur_d.ctl.kill = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      state_q     <= S_IDLE;
      k_q         <= '0;
      cur_q       <= '0;
      rbuf_q      <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + QW'(1);
      if (pop)  rd_q <= rd_q + QW'(1);
      cnt_q       <= cnt_q + (QW+1)'(push) - (QW+1)'(pop);
      state_q     <= state_d;
      k_q         <= k_d;
      cur_q       <= cur_d;
      rbuf_q      <= rbuf_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (state_q == S_DONE && !cur_q.ctl.kill) begin
      rsp_valid[cur_q.chan] = 1'b1;
      if (!cur_q.ctl.we) rsp_data = rbuf_q;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_we    = ram_we_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte-RAM model, response and RAM-write
// scoreboards, plus a fixed-priority instance for the arbitration check.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_we, fp_valid;
  logic [3:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        flush;
  logic [1:0]  req_ready, rsp_valid, fp_ready, fp_rsp_valid;
  logic [31:0] rsp_data, ram_addr, fp_rsp_data, fp_ram_addr;
  logic [7:0]  ram_wdata, ram_rdata, fp_ram_wdata;
  logic        ram_we, fp_ram_we;

  typedef struct { int ch; logic [31:0] data; } rsp_t;
  typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
  rsp_t sb[$];
  wr_t  wq[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] mem [1024];

  always #5 clk = ~clk;

  mem_ctrl #(.NCH(2), .DEPTH(8), .ADDR_W(32), .DATA_W(32), .RR_MODE(1), .FLUSH_MASK(2'b01)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .flush(flush), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_rdata(ram_rdata));

  mem_ctrl #(.NCH(2), .DEPTH(8), .ADDR_W(32), .DATA_W(32), .RR_MODE(0), .FLUSH_MASK(2'b01)) dut_fp (
    .clk(clk), .rst(rst), .req_valid(fp_valid), .req_ready(fp_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(fp_rsp_valid),
    .rsp_data(fp_rsp_data), .flush(1'b0), .ram_addr(fp_ram_addr), .ram_wdata(fp_ram_wdata),
    .ram_we(fp_ram_we), .ram_rdata(8'h00));

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h100] = 8'h11; mem[10'h101] = 8'h22; mem[10'h102] = 8'h33; mem[10'h103] = 8'h44;
  end

  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr[9:0]];
    if (ram_we) mem[ram_addr[9:0]] <= ram_wdata;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  rsp_t re;
  wr_t  we_e;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (rsp_valid !== 2'b00) begin
        if (sb.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
        else begin
          re = sb.pop_front();
          chk("rsp_chan", rsp_valid, 64'd1 << re.ch);
          chk("rsp_data", rsp_data, re.data);
        end
      end
      if (ram_we === 1'b1) begin
        if (wq.size() == 0) chk("ram_we_unexpected", ram_we, 0);
        else begin
          we_e = wq.pop_front();
          chk("ram_wr_addr", ram_addr, we_e.a);
          chk("ram_wr_data", ram_wdata, we_e.d);
        end
      end
    end
  end

  // Drive one request and return 1 time unit after the accepting edge.
  task automatic send(input int ch, input logic we, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] wd);
    logic ok;
    ok = 1'b0;
    @(negedge clk);
    req_valid[ch] = 1'b1; req_we[ch] = we; req_size[2*ch +: 2] = sz;
    req_addr[32*ch +: 32] = a; req_wdata[32*ch +: 32] = wd;
    for (int n = 0; n < 100; n++) begin
      #1;
      if (req_ready[ch]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("accept", ok, 1);
    @(posedge clk); #1;
    req_valid[ch] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] exp;
    rst = 1'b0; req_valid = '0; fp_valid = '0; req_we = '0; req_size = '0;
    req_addr = '0; req_wdata = '0; flush = 1'b0;
    #3;
    chk("rst_rsp_valid", rsp_valid, 0); chk("rst_rsp_data", rsp_data, 0);
    chk("rst_ram_addr", ram_addr, 0);   chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_wdata", ram_wdata, 0); chk("rst_req_ready", req_ready, 0);
    repeat (2) @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);

    // Word read from ch1: bytes stream out of 0x100..0x103, response at t+6.
    send(1, 1'b0, 2'd2, 32'h100, 32'h0);
    sb.push_back('{1, 32'h44332211});
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("wrd_addr", ram_addr, 32'h100 + i); chk("wrd_we", ram_we, 0);
    end
    @(posedge clk); #1; chk("wrd_early", rsp_valid, 0);
    @(posedge clk); #1; chk("wrd_valid", rsp_valid, 2'b10); chk("wrd_data", rsp_data, 32'h44332211);

    // Half store crossing 0x1FF/0x200, response at t+3.
    repeat (3) @(negedge clk);
    wq.push_back('{32'h1FF, 8'hDD}); wq.push_back('{32'h200, 8'hCC}); sb.push_back('{1, 32'h0});
    send(1, 1'b1, 2'd1, 32'h1FF, 32'hAABBCCDD);
    @(posedge clk); #1; chk("hst_we0", ram_we, 1); chk("hst_a0", ram_addr, 32'h1FF); chk("hst_d0", ram_wdata, 8'hDD);
    @(posedge clk); #1; chk("hst_we1", ram_we, 1); chk("hst_a1", ram_addr, 32'h200); chk("hst_d1", ram_wdata, 8'hCC);
    @(posedge clk); #1; chk("hst_we_off", ram_we, 0); chk("hst_valid", rsp_valid, 2'b10); chk("hst_data", rsp_data, 0);

    // Both channels contend; pointer sits at 0 after the two ch1 grants.
    repeat (3) @(negedge clk);
    req_valid = 2'b11; fp_valid = 2'b11; req_we = 2'b00; req_size = 4'b0000;
    req_addr = {32'h100, 32'h100};
    for (int i = 0; i < 6; i++) begin
      #1;
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      chk("rr_grant", req_ready, exp);
      chk("fp_grant", fp_ready, 2'b01);
      sb.push_back('{(i % 2 == 0) ? 0 : 1, 32'h11});
      @(negedge clk);
    end
    req_valid = '0; fp_valid = '0;
    repeat (60) @(negedge clk);

    // Continuous ch0 word reads: pops every 7 cycles, queue fills, then one slot frees.
    req_valid = 2'b01; req_size = 4'b0010; req_addr[31:0] = 32'h100;
    for (int i = 0; i < 17; i++) begin
      #1;
      exp = (i < 10 || i == 16) ? 2'b01 : 2'b00;
      chk("full_ready", req_ready, exp);
      if (exp != 2'b00) sb.push_back('{0, 32'h44332211});
      @(negedge clk);
    end
    req_valid = '0;
    repeat (100) @(negedge clk);
    chk("full_drained", sb.size(), 0);

    // Flush with ch0 read in flight, ch1 store and ch0 read queued.
    sb.push_back('{1, 32'h0}); wq.push_back('{32'h300, 8'h5A});
    send(0, 1'b0, 2'd2, 32'h100, 32'h0);
    send(1, 1'b1, 2'd0, 32'h300, 32'h5A);
    send(0, 1'b0, 2'd0, 32'h180, 32'h0);
    @(negedge clk);
    flush = 1'b1; req_valid[0] = 1'b1; req_we[0] = 1'b0; req_size[1:0] = 2'd0; req_addr[31:0] = 32'h102;
    #1; chk("fl_accept", req_ready, 2'b01);
    sb.push_back('{0, 32'h33});
    @(posedge clk); #1; flush = 1'b0; req_valid = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("fl_skip_addr", ram_addr == 32'h180, 0);
    end
    chk("fl_sb_empty", sb.size(), 0);
    chk("fl_wq_empty", wq.size(), 0);

    // Reset during the second byte of a word store.
    wq.push_back('{32'h300, 8'h04}); wq.push_back('{32'h301, 8'h03});
    send(1, 1'b1, 2'd2, 32'h300, 32'h01020304);
    @(posedge clk); @(posedge clk); @(negedge clk); #1;
    chk("rm_we_pre", ram_we, 1); chk("rm_addr_pre", ram_addr, 32'h301);
    req_valid = 2'b01; rst = 1'b0; #1;
    chk("rm_we", ram_we, 0); chk("rm_addr", ram_addr, 0); chk("rm_wdata", ram_wdata, 0);
    chk("rm_rsp_valid", rsp_valid, 0); chk("rm_rsp_data", rsp_data, 0); chk("rm_ready", req_ready, 0);
    req_valid = '0;
    @(negedge clk); @(negedge clk); rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("rm_wq_empty", wq.size(), 0);
    send(0, 1'b0, 2'd0, 32'h103, 32'h0);
    sb.push_back('{0, 32'h44});
    @(posedge clk); #1; chk("rm_post_addr", ram_addr, 32'h103);
    @(posedge clk); #1; chk("rm_post_early", rsp_valid, 0);
    @(posedge clk); #1; chk("rm_post_valid", rsp_valid, 2'b01); chk("rm_post_data", rsp_data, 32'h44);

    repeat (10) @(negedge clk);
    chk("end_sb_empty", sb.size(), 0);
    chk("end_wq_empty", wq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
